// File: rtl/wb_port_arbiter_pkg.sv
// Shared register-file bus widths and arbiter state codes for the writeback port arbiter.
package wb_port_arbiter_pkg;

    localparam int unsigned REG_BUS_W  = 32;
    localparam int unsigned REG_ADDR_W = 5;

    // Writes to the zero register are never performed.
    localparam logic [REG_ADDR_W-1:0] NOP_REG_ADDR = '0;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_WAIT  = 2'd1,
        ARB_STALL = 2'd2
    } arb_state_e;

endpackage

// File: rtl/wb_mc_fifo.sv
// Circular buffer of late multi-cycle results {live, addr, data} with kill-by-address,
// so a younger pipeline write to the same register can supersede a buffered one.
module wb_mc_fifo
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W = REG_BUS_W,
    parameter int unsigned ADDR_W = REG_ADDR_W,
    parameter int unsigned DEPTH  = 2,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push_i,
    input  logic              push_live_i,
    input  logic [ADDR_W-1:0] push_addr_i,
    input  logic [DATA_W-1:0] push_data_i,
    input  logic              pop_i,
    input  logic              kill_i,
    input  logic [ADDR_W-1:0] kill_addr_i,
    output logic [CNT_W-1:0]  count_o,
    output logic              head_live_o,
    output logic [ADDR_W-1:0] head_addr_o,
    output logic [DATA_W-1:0] head_data_o
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DEPTH-1:0]  live_q;
    logic [ADDR_W-1:0] addr_q [DEPTH];
    logic [DATA_W-1:0] data_q [DEPTH];
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [CNT_W-1:0]  count_q;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) return '0;
        return p + PTR_W'(1);
    endfunction

    // Kill is applied before the push so a same-cycle push keeps its own live bit.
    always_ff @(posedge clk) begin
        if (rst) begin
            live_q   <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (kill_i) begin
                for (int unsigned i = 0; i < DEPTH; i++) begin
                    if (addr_q[i] == kill_addr_i) live_q[i] <= 1'b0;
                end
            end
            if (push_i) begin
                live_q[wr_ptr_q] <= push_live_i;
                addr_q[wr_ptr_q] <= push_addr_i;
                data_q[wr_ptr_q] <= push_data_i;
                wr_ptr_q         <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign count_o     = count_q;
    assign head_live_o = live_q[rd_ptr_q];
    assign head_addr_o = addr_q[rd_ptr_q];
    assign head_data_o = data_q[rd_ptr_q];

endmodule

// File: rtl/wb_port_arbiter.sv
// Shares the regfile write port between pipeline writeback (always wins) and buffered
// multi-cycle results; requests a pipeline stall when a buffered result starves.
module wb_port_arbiter
    import wb_port_arbiter_pkg::*;
#(
    parameter int unsigned DATA_W       = REG_BUS_W,
    parameter int unsigned ADDR_W       = REG_ADDR_W,
    parameter int unsigned DEPTH        = 2,
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] wb_wd,
    input  logic              wb_wreg,
    input  logic [DATA_W-1:0] wb_wdata,
    input  logic              mc_valid,
    output logic              mc_ready,
    input  logic [ADDR_W-1:0] mc_wd,
    input  logic [DATA_W-1:0] mc_wdata,
    output logic              rf_we,
    output logic [ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic              stallreq
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned AGE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
    localparam logic [AGE_W-1:0] LIMIT_C = AGE_W'(STARVE_LIMIT);
    localparam logic [ADDR_W-1:0] NOP_C  = ADDR_W'(NOP_REG_ADDR);

    logic [CNT_W-1:0]  count_q;
    logic [CNT_W-1:0]  count_d;
    logic              head_live;
    logic [ADDR_W-1:0] head_addr;
    logic [DATA_W-1:0] head_data;
    logic              grant;
    logic              pop;
    logic              store;
    logic              store_live;
    logic [AGE_W-1:0]  age_q;
    logic [AGE_W-1:0]  age_d;
    arb_state_e        state_q;
    logic              stallreq_q;

    assign mc_ready   = !rst && (count_q < DEPTH_C);
    assign grant      = !rst && wb_wreg && (wb_wd != NOP_C);
    assign pop        = !rst && !grant && (count_q != '0);
    // Zero-register results are accepted but dropped; a same-cycle pipeline write supersedes.
    assign store      = mc_valid && mc_ready && (mc_wd != NOP_C);
    assign store_live = !(grant && (mc_wd == wb_wd));
    assign count_d    = count_q + CNT_W'(store) - CNT_W'(pop);

    wb_mc_fifo #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst         (rst),
        .push_i      (store),
        .push_live_i (store_live),
        .push_addr_i (mc_wd),
        .push_data_i (mc_wdata),
        .pop_i       (pop),
        .kill_i      (grant),
        .kill_addr_i (wb_wd),
        .count_o     (count_q),
        .head_live_o (head_live),
        .head_addr_o (head_addr),
        .head_data_o (head_data)
    );

    // Write-port select: pipeline, then FIFO head, else idle.
    always_comb begin
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (grant) begin
            rf_we    = 1'b1;
            rf_waddr = wb_wd;
            rf_wdata = wb_wdata;
        end else if (pop) begin
            rf_we    = head_live;
            rf_waddr = head_addr;
            rf_wdata = head_data;
        end
    end

    always_comb begin
        age_d = age_q;
        if (pop || (count_q == '0)) age_d = '0;
        else if (age_q != LIMIT_C)  age_d = age_q + AGE_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) age_q <= '0;
        else     age_q <= age_d;
    end

    // Starvation FSM; stallreq is registered alongside the state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ARB_IDLE;
            stallreq_q <= 1'b0;
        end else begin
            case (state_q)
                ARB_IDLE: begin
                    if (count_d != '0) state_q <= ARB_WAIT;
                end
                ARB_WAIT: begin
                    if (count_d == '0) begin
                        state_q <= ARB_IDLE;
                    end else if (age_d == LIMIT_C) begin
                        state_q    <= ARB_STALL;
                        stallreq_q <= 1'b1;
                    end
                end
                ARB_STALL: begin
                    if (pop) begin
                        stallreq_q <= 1'b0;
                        state_q    <= (count_d == '0) ? ARB_IDLE : ARB_WAIT;
                    end
                end
                default: begin
                    state_q    <= ARB_IDLE;
                    stallreq_q <= 1'b0;
                end
            endcase
        end
    end

    assign stallreq = stallreq_q;

endmodule
